// File: rtl/csa_pipe_if.sv
// Handshake and operand/result bus for the two-stage carry-select adder.
// The master drives operands and accepts results; the slave is the adder.
interface csa_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, ovf
    );
endinterface

// File: rtl/csa_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage 1 forms per-block candidates, stage 2 resolves the block carry chain.
module csa_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    csa_pipe_if.slave  bus
);
    localparam int NB = WIDTH / BLK;

    // Handshake
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_load;
    logic w_in_fire;

    // Stage 1 candidates; block 0 only needs the c0 result
    logic [BLK-1:0] r_s1_sum0 [NB];
    logic           r_s1_c0   [NB];
    logic [BLK-1:0] r_s1_sum1 [1:NB-1];
    logic           r_s1_c1   [1:NB-1];
    logic           r_s1_a_msb;
    logic           r_s1_b_msb;

    logic [BLK-1:0] w_sum0 [NB];
    logic           w_c0   [NB];
    logic [BLK-1:0] w_sum1 [1:NB-1];
    logic           w_c1   [1:NB-1];

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Stage 2 / outputs
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_carry_nxt;
    logic             w_ovf_nxt;

    // Stage 2 accepts when empty or draining this cycle; the out_ready ->
    // in_ready combinational path lets a full pipe stream at one beat/cycle.
    assign w_s2_load    = !r_s2_valid || bus.out_ready;
    assign bus.in_ready = !r_s1_valid || w_s2_load;
    assign w_in_fire    = bus.in_valid && bus.in_ready;

    assign w_b_eff   = bus.b ^ {WIDTH{bus.sub}};
    assign w_cin_eff = bus.sub | bus.cin;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic [BLK:0] w_t0;
        if (k == 0) begin : g_first
            assign w_t0 = {1'b0, bus.a[BLK-1:0]} + {1'b0, w_b_eff[BLK-1:0]}
                        + {{BLK{1'b0}}, w_cin_eff};
        end else begin : g_rest
            logic [BLK:0] w_t1;
            assign w_t0 = {1'b0, bus.a[k*BLK +: BLK]} + {1'b0, w_b_eff[k*BLK +: BLK]};
            assign w_t1 = {1'b0, bus.a[k*BLK +: BLK]} + {1'b0, w_b_eff[k*BLK +: BLK]}
                        + {{BLK{1'b0}}, 1'b1};
            assign w_sum1[k] = w_t1[BLK-1:0];
            assign w_c1[k]   = w_t1[BLK];
        end
        assign w_sum0[k] = w_t0[BLK-1:0];
        assign w_c0[k]   = w_t0[BLK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
        end
    end

    // NOTE: stage-1 candidates carry no reset; the valid bit alone qualifies
    // them, so leaving them unreset saves reset fan-out without exposing junk.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            for (int k = 0; k < NB; k++) begin
                r_s1_sum0[k] <= w_sum0[k];
                r_s1_c0[k]   <= w_c0[k];
            end
            for (int k = 1; k < NB; k++) begin
                r_s1_sum1[k] <= w_sum1[k];
                r_s1_c1[k]   <= w_c1[k];
            end
            r_s1_a_msb <= bus.a[WIDTH-1];
            r_s1_b_msb <= w_b_eff[WIDTH-1];
        end
    end

    // Ripple the block carries upward, picking each block's candidate pair.
    always_comb begin
        logic v_cy;
        w_sum_nxt          = '0;
        w_sum_nxt[BLK-1:0] = r_s1_sum0[0];
        v_cy               = r_s1_c0[0];
        for (int k = 1; k < NB; k++) begin
            w_sum_nxt[k*BLK +: BLK] = v_cy ? r_s1_sum1[k] : r_s1_sum0[k];
            v_cy                    = v_cy ? r_s1_c1[k]   : r_s1_c0[k];
        end
        w_carry_nxt = v_cy;
        w_ovf_nxt   = (r_s1_a_msb == r_s1_b_msb) && (w_sum_nxt[WIDTH-1] != r_s1_a_msb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_s2_load && r_s1_valid) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.sum       = r_sum;
    assign bus.carry     = r_carry;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_csa_pipe.sv
// Directed and random check of csa_pipe (WIDTH=8, BLK=4) against a
// scoreboard of expected results queued at each input transfer.
module tb_csa_pipe;
    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    res_t sb[$];

    csa_pipe_if #(.WIDTH(8)) bus ();

    csa_pipe #(.WIDTH(8), .BLK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic [7:0] s, input logic c, input logic o);
        res_t r;
        r.sum   = s;
        r.carry = c;
        r.ovf   = o;
        return r;
    endfunction

    // Reference: (a + B' + c0) over WIDTH+1 bits.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        logic [7:0] be;
        logic       c0;
        logic [8:0] t;
        res_t       r;
        be      = b ^ {8{sub}};
        c0      = sub ? 1'b1 : cin;
        t       = {1'b0, a} + {1'b0, be} + {8'd0, c0};
        r.sum   = t[7:0];
        r.carry = t[8];
        r.ovf   = (a[7] == be[7]) && (t[7] != a[7]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every beat leaving the DUT is compared with the oldest entry.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL extra_beat: observed sum %0h with empty scoreboard", bus.sum);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("sum",   32'(bus.sum),   32'(e.sum));
                check("carry", 32'(bus.carry), 32'(e.carry));
                check("ovf",   32'(bus.ovf),   32'(e.ovf));
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input res_t exp);
        int n;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: in_ready observed 0 expected 1");
        end else begin
            sb.push_back(exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Drop in_valid and scramble the operands, which must then be ignored.
    task automatic drop();
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.cin      = 1'($urandom);
        bus.sub      = 1'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_carry",     32'(bus.carry),     32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Block carry 0x0F+0x01, with latency measurement
        @(posedge clk);
        #1;
        send(8'h0F, 8'h01, 1'b0, 1'b0, mk(8'h10, 1'b0, 1'b0));
        drop();
        @(negedge clk);
        check("lat_cycle1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2", 32'(bus.out_valid), 32'd1);
        wait_cycles(3);

        // Directed corner cases back to back
        send(8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0));
        send(8'hFF, 8'h01, 1'b1, 1'b0, mk(8'h01, 1'b1, 1'b0));
        send(8'h05, 8'h07, 1'b0, 1'b1, mk(8'hFE, 1'b0, 1'b0));
        send(8'h80, 8'h01, 1'b1, 1'b1, mk(8'h7F, 1'b1, 1'b1));
        send(8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1));
        drop();
        wait_cycles(4);
        check("directed_drain", 32'(sb.size()), 32'd0);

        // Backpressure: two beats buffered, third refused, output held
        bus.out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 1'b0, mk(8'h33, 1'b0, 1'b0));
        send(8'h40, 8'h40, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1));
        bus.a        = 8'h01;
        bus.b        = 8'h02;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_sum",  32'(bus.sum),       32'h33);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(8'h01, 8'h02, 1'b0, 1'b0, mk(8'h03, 1'b0, 1'b0));
        drop();
        @(negedge clk);
        check("bp_stream2", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("bp_stream3", 32'(bus.out_valid), 32'd1);
        wait_cycles(3);
        check("bp_drain", 32'(sb.size()), 32'd0);

        // Random back-to-back stream at full throughput
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        drop();
        wait_cycles(4);
        check("rand_drain", 32'(sb.size()), 32'd0);

        // Reset mid-flight with two beats buffered
        bus.out_ready = 1'b0;
        send(8'h21, 8'h10, 1'b0, 1'b0, mk(8'h31, 1'b0, 1'b0));
        send(8'h22, 8'h10, 1'b0, 1'b0, mk(8'h32, 1'b0, 1'b0));
        drop();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum",       32'(bus.sum),       32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
            check("midrst_in_ready", 32'(bus.in_ready),  32'd1);
        end
        @(posedge clk);
        #1;
        send(8'h5A, 8'h3C, 1'b1, 1'b1, mk(8'h1E, 1'b1, 1'b0));
        drop();
        @(negedge clk);
        check("midrst_lat1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("midrst_lat2", 32'(bus.out_valid), 32'd1);
        wait_cycles(3);
        check("final_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csa_pipe.md
CSA_PIPE -- requirements
Module: csa_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits; SHALL be a multiple of BLK and at least 2*BLK.
REQ-002 Parameter BLK, default 4: carry-select block width in bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B, unsigned or two's complement.
REQ-009 cin  input  1  carry-in; used only in add mode.
REQ-010 sub  input  1  mode select: 0 = A+B+cin, 1 = A-B.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 carry  output  1  carry-out of the MSB; in sub mode 1 = no borrow.
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 The beat transfers on an input edge when in_valid=1 and in_ready=1; the result transfers on an output edge when out_valid=1 and out_ready=1.
REQ-017 Effective operand: B' = b XOR {WIDTH{sub}}; effective carry-in: c0 = sub ? 1 : cin.
REQ-018 Stage 1 register: block 0 sum and carry computed with c0; each block k>=1 registers two candidates, sum/carry for carry-in 0 and for carry-in 1; a[WIDTH-1] and B'[WIDTH-1] are also registered.
REQ-019 Stage 2 register: block carries resolved in order from block 0 upward; each block k>=1 selects its candidate by the resolved carry of block k-1; the selected sums are concatenated into sum, and the top block carry drives carry.
REQ-020 ovf = (a_msb == B'_msb) AND (sum_msb != a_msb), registered with sum.
REQ-021 Latency: exactly 2 cycles from input transfer to out_valid=1 when no stall occurs; throughput is 1 beat/cycle when out_ready is held at 1.
REQ-022 Each stage holds a valid bit; stage 2 loads when it is empty or its content transfers out in the same cycle; stage 1 loads when it is empty or it moves to stage 2 in the same cycle.
REQ-023 in_ready = NOT s1_valid OR (NOT s2_valid OR out_ready); the combinational path from out_ready to in_ready is permitted.
REQ-024 While out_valid=1 and out_ready=0, sum, carry and ovf SHALL hold stable and no beat is lost or duplicated; at most 2 beats are buffered.
REQ-025 A transfer out and a transfer in occurring on the same edge both take effect; the order of beats is preserved.
REQ-026 Inputs a, b, cin and sub are sampled only on the transfer edge; their values outside a transfer SHALL have no effect.
REQ-027 All WIDTH/BLK combinations SHALL give results identical to (a + B' + c0) taken over WIDTH+1 bits.

Reset
REQ-028 While rst_n=0: s1_valid=0, s2_valid=0, out_valid=0, sum=0, carry=0, ovf=0; in_ready=1 from the cycle after deassertion.
REQ-029 Assertion mid-operation discards every buffered beat immediately, without waiting for a clock edge; no stale result appears after release.
REQ-030 Datapath registers other than the valid bits and the outputs are not reset.

Verification (WIDTH=8, BLK=4)
REQ-031 Add with block carry: a=0x0F, b=0x01, cin=0, sub=0 -> 2 cycles later sum=0x10, carry=0, ovf=0.
REQ-032 Full wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1, ovf=0; with cin=1 -> sum=0x01, carry=1.
REQ-033 Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0, ovf=0; with a=0x80, b=0x01, sub=1 -> sum=0x7F, carry=1, ovf=1.
REQ-034 Signed overflow on add: a=0x7F, b=0x01 -> sum=0x80, ovf=1.
REQ-035 Backpressure: hold out_ready=0 and offer 3 beats back to back -> 2 accepted, then in_ready=0; the first result is held stable; release out_ready -> results appear in order on consecutive cycles, with no loss or duplication.
REQ-036 Reset mid-flight: assert rst_n=0 for 1 cycle while 2 beats are buffered -> out_valid=0 at once and stays 0; the first new beat gives its result 2 cycles after its input transfer.
